// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W    = 10;
  localparam int unsigned IMEM_DEPTH     = 1 << IMEM_ADDR_W;
  localparam int unsigned HDR_LEN        = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = 8 * HDR_LEN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Shifts stream bytes MSB-first into a 32-bit word and flags the last byte of each word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] byte_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], byte_in};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Asserted in the same cycle the final byte is accepted so the FSM can move to WRITE.
  assign word_ready = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: header count, big-endian words, XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  hdr_count;
  logic [0:0]        hdr_idx;
  logic [7:0]        checksum;
  logic [ADDR_W:0]   wl_inc;
  logic              xfer;
  logic              restart;
  logic              hdr_last;
  logic              pack_en;
  logic              word_ready;
  logic              last_word;
  logic [31:0]       word;

  assign xfer      = byte_valid && byte_ready;
  assign restart   = start && (state inside {S_IDLE, S_DONE, S_ERR});
  assign hdr_last  = (hdr_idx == 1'(HDR_LEN - 1));
  assign hdr_count = {count_q[7:0], byte_in};
  assign wl_inc    = words_loaded + 1'b1;
  assign last_word = ({{(CNT_W - ADDR_W - 1){1'b0}}, wl_inc} == count_q);
  assign pack_en   = (state == S_DATA) && xfer;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .shift_en   (pack_en),
    .byte_in    (byte_in),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_HDR;
      S_HDR: begin
        if (xfer && hdr_last) begin
          if (32'(hdr_count) > DEPTH) state_nxt = S_ERR;
          else if (hdr_count == '0)   state_nxt = S_CHK;
          else                        state_nxt = S_DATA;
        end
      end
      S_DATA:  if (word_ready) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_word ? S_CHK : S_DATA;
      S_CHK: begin
        if (xfer) state_nxt = (byte_in == checksum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      hdr_idx      <= '0;
      checksum     <= '0;
      words_loaded <= '0;
    end else if (restart) begin
      count_q      <= '0;
      hdr_idx      <= '0;
      checksum     <= '0;
      words_loaded <= '0;
    end else begin
      if (state == S_HDR && xfer) begin
        count_q <= hdr_count;
        hdr_idx <= hdr_idx + 1'b1;
      end
      if (pack_en)          checksum     <= checksum ^ byte_in;
      if (state == S_WRITE) words_loaded <= wl_inc;
    end
  end

  // All handshake/status outputs are pure decodes of the registered state.
  assign byte_ready = state inside {S_HDR, S_DATA, S_CHK};
  assign mem_we     = (state == S_WRITE);
  assign cpu_hold   = state inside {S_HDR, S_DATA, S_WRITE, S_CHK, S_ERR};
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign mem_addr   = {{(32 - ADDR_W - 3){1'b0}}, words_loaded, 2'b00};
  assign mem_wdata  = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [10:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rdy_in_write = 0;

  imem_loader #(.ADDR_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      if (byte_ready !== 1'b0) rdy_in_write++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rdy_in_write = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept_timeout", 32'(n < 40), 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++)
      send_byte(w[31 - 8*i -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"},    32'(mem_we),     32'd0);
    check({tag, "_addr"},  mem_addr,        32'd0);
    check({tag, "_wdata"}, mem_wdata,       32'd0);
    check({tag, "_flags"}, {29'd0, cpu_hold, done, error}, 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(byte_ready), 32'd0);

    // Count 1
    clear_log();
    pulse_start();
    check("c1_hold_hdr", 32'(cpu_hold), 32'd1);
    check("c1_ready_hdr", 32'(byte_ready), 32'd1);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h0022_1820, 0);
    send_byte(8'h1A, 0);
    @(negedge clk);
    check("c1_flags", {29'd0, cpu_hold, done, error}, 32'b010);
    check("c1_words", 32'(words_loaded), 32'd1);
    check("c1_nwr", 32'(wr_addr_q.size()), 32'd1);
    check("c1_addr0", wr_addr_q[0], 32'h0);
    check("c1_data0", wr_data_q[0], 32'h0022_1820);
    check("c1_ready_done", 32'(byte_ready), 32'd0);

    // Count 2 with WRITE latency check
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h0022_1820, 0);
    @(negedge clk);
    check("c2_we_after_4th", 32'(mem_we), 32'd1);
    check("c2_ready_in_write", 32'(byte_ready), 32'd0);
    check("c2_wr_addr_live", mem_addr, 32'h0);
    send_word(32'h0061_2022, 0);
    send_byte(8'h79, 0);
    @(negedge clk);
    check("c2_flags", {29'd0, cpu_hold, done, error}, 32'b010);
    check("c2_words", 32'(words_loaded), 32'd2);
    check("c2_nwr", 32'(wr_addr_q.size()), 32'd2);
    check("c2_addr1", wr_addr_q[1], 32'h4);
    check("c2_data0", wr_data_q[0], 32'h0022_1820);
    check("c2_data1", wr_data_q[1], 32'h0061_2022);
    check("c2_rdy_in_write", 32'(rdy_in_write), 32'd0);

    // Checksum error, then recovery
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h0022_1820, 0);
    send_byte(8'h1B, 0);
    @(negedge clk);
    check("ck_err_flags", {29'd0, cpu_hold, done, error}, 32'b101);
    repeat (3) @(negedge clk);
    check("ck_err_held", {29'd0, cpu_hold, done, error}, 32'b101);
    pulse_start();
    check("ck_restart_flags", {29'd0, cpu_hold, done, error}, 32'b100);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h0022_1820, 0);
    send_byte(8'h1A, 0);
    @(negedge clk);
    check("ck_recover_flags", {29'd0, cpu_hold, done, error}, 32'b010);

    // Oversize count
    clear_log();
    pulse_start();
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    @(negedge clk);
    check("ovr_flags", {29'd0, cpu_hold, done, error}, 32'b101);
    check("ovr_nwr", 32'(wr_addr_q.size()), 32'd0);
    check("ovr_words", 32'(words_loaded), 32'd0);

    // Zero count
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    check("zero_in_chk_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("zero_flags", {29'd0, cpu_hold, done, error}, 32'b010);
    check("zero_nwr", 32'(wr_addr_q.size()), 32'd0);

    // Backpressure gaps plus ignored start mid-DATA
    clear_log();
    pulse_start();
    send_byte(8'h00, 3); send_byte(8'h02, 5);
    send_byte(8'h00, 2); send_byte(8'h22, 4);
    pulse_start();
    check("bp_ign_start_ready", 32'(byte_ready), 32'd1);
    check("bp_ign_start_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h18, 1); send_byte(8'h20, 5);
    send_word(32'h0061_2022, 5);
    send_byte(8'h79, 3);
    @(negedge clk);
    check("bp_flags", {29'd0, cpu_hold, done, error}, 32'b010);
    check("bp_words", 32'(words_loaded), 32'd2);
    check("bp_nwr", 32'(wr_addr_q.size()), 32'd2);
    check("bp_addr1", wr_addr_q[1], 32'h4);
    check("bp_data0", wr_data_q[0], 32'h0022_1820);
    check("bp_data1", wr_data_q[1], 32'h0061_2022);

    // Reset mid-load
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h22, 0);
    @(negedge clk);
    check("rst_pre_hold", 32'(cpu_hold), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_nwr", 32'(wr_addr_q.size()), 32'd0);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h0022_1820, 0);
    send_byte(8'h1A, 0);
    @(negedge clk);
    check("midrst_flags", {29'd0, cpu_hold, done, error}, 32'b010);
    check("midrst_nwr2", 32'(wr_addr_q.size()), 32'd1);
    check("midrst_addr0", wr_addr_q[0], 32'h0);
    check("midrst_data0", wr_data_q[0], 32'h0022_1820);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the fetch unit reads.
- Receives a byte stream (valid/ready) carrying a word count, big-endian instruction words and an XOR checksum.
- Assembles 32-bit words and writes them to consecutive word slots from byte address 0.
- Holds the CPU (PC update) until the image is loaded and verified.

Parameters:
- ADDR_W, 10, word-address width; capacity is 2^ADDR_W words (1024).

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- Byte_in  in  8  stream data byte.
- Byte_valid  in  1  Byte_in is valid this cycle.
- Byte_ready  out  1  loader accepts a byte this cycle. Transfer occurs when valid and ready are both high on a posedge.
- Mem_we  out  1  one-cycle write strobe to instruction memory.
- Mem_addr  out  32  byte address of the write, {word_idx, 2'b00}.
- Mem_wdata  out  32  instruction word.
- Cpu_hold  out  1  freezes the PC while high.
- Done  out  1  load completed and checksum matched.
- Error  out  1  load failed (oversize count or checksum mismatch).
- Words_loaded  out  ADDR_W+1  number of words written so far.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal counters and checksum 0.
- Reset mid-load aborts immediately. Words already written stay in memory; Cpu_hold drops to 0.
- FSM states: IDLE, HDR, DATA, WRITE, CHK, DONE, ERR.
- IDLE: Byte_ready=0. Start moves to HDR and does the following in the same transition:
  - sets Cpu_hold=1;
  - clears Done, Error, Words_loaded, the byte index and the checksum.
- HDR: Byte_ready=1. Accepts 2 bytes forming a 16-bit count, MSB first. After the second byte:
  - count > 2^ADDR_W goes to ERR;
  - count == 0 goes to CHK;
  - otherwise goes to DATA.
- DATA: Byte_ready=1.
  - Shifts bytes into a 32-bit word, MSB first.
  - XORs every data byte into an 8-bit running checksum.
  - The 4th accepted byte moves to WRITE.
- WRITE: exactly one cycle with Byte_ready=0.
  - Mem_we=1, Mem_addr={Words_loaded, 2'b00}, Mem_wdata=assembled word.
  - Words_loaded increments at the end of this cycle.
  - If the incremented value equals count, go to CHK; else return to DATA.
- Latency: 4th byte accepted at posedge N gives Mem_we high during cycle N to N+1. The next byte is accepted no earlier than posedge N+2.
- CHK: Byte_ready=1. Accepts one byte. If it equals the running checksum, go to DONE; else go to ERR.
- DONE: Done=1, Cpu_hold=0, Byte_ready=0. Held until Start or reset.
- ERR: Error=1, Cpu_hold stays 1 (CPU must not run a partial image), Byte_ready=0. Held until Start or reset.
- Start in HDR, DATA, WRITE or CHK is ignored.
- Start in DONE or ERR restarts the load (same actions as from IDLE).
- Byte_valid low in any receiving state stalls with no state change. Gaps of any length are legal.
- Words_loaded never exceeds 2^ADDR_W; its extra bit is what allows the full count.
- Mem_addr wraps never occurs, because oversize counts are rejected in HDR.
- Byte_ready is a registered-state decode only and never depends on Byte_valid.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams);
  - header length (2) and bytes per word (4);
  - instruction memory depth (2^ADDR_W).
- One natural sub-module, imem_byte_packer: 4-byte shift/assemble with byte index and word-ready flag.
- The FSM, counters and checksum remain in the top module.

Test Plan:
- Count 1: stream 00 01 | 00 22 18 20 | 1A -> one Mem_we with addr 0x0, data 0x00221820; then Done=1, Cpu_hold=0, Words_loaded=1.
- Count 2: stream 00 02 | 00 22 18 20 | 00 61 20 22 | 79 -> writes 0x0=0x00221820 and 0x4=0x00612022; Done=1. Byte_ready is low during each WRITE cycle.
- Checksum error: same as count 1 but checksum byte 0x1B -> Error=1, Cpu_hold=1, Done=0. A following Start plus a correct stream -> Done=1.
- Count boundaries: count 0x0401 -> ERR right after header with no Mem_we. Count 0x0000 with checksum 00 -> Done=1 and no writes.
- Backpressure and ignored Start: random Byte_valid gaps of 0-5 cycles plus a Start pulse mid-DATA -> identical writes and result to the gap-free case.
- Reset mid-load: Rst_n low after 2 of 4 data bytes -> all outputs 0 asynchronously, no Mem_we. A new Start loads correctly from address 0.
